// File: rtl/pe_accum_stage_if.sv
// Handshake and configuration bundle for pe_accum_stage: start/config,
// PE input stream, result stream and status flags.
interface pe_accum_stage_if #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 48,
  parameter int LEN_W  = 16
);
  logic                     start;
  logic        [LEN_W-1:0]  cfg_len;
  logic        [1:0]        cfg_op;
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_ready;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_data;
  logic        [LEN_W-1:0]  out_count;
  logic                     busy;
  logic                     sat;

  modport slave (
    input  start, cfg_len, cfg_op, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_count, busy, sat
  );

  modport master (
    output start, cfg_len, cfg_op, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_count, busy, sat
  );
endinterface

// File: rtl/pe_accum_stage.sv
// Reduction stage folding a stream of signed PE results into one sum/max/min.
// Define PE_ACCUM_SATURATE_EN for saturating sums with a sticky sat flag; otherwise sums wrap.
module pe_accum_stage #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 48,
  parameter int LEN_W  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  pe_accum_stage_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [1:0] OP_MAX = 2'b01;
  localparam logic [1:0] OP_MIN = 2'b10;

`ifdef PE_ACCUM_SATURATE_EN
  // Add one guard bit; disagreement between the top two bits means overflow.
  function automatic logic signed [ACC_W-1:0] acc_add(
    input  logic signed [ACC_W-1:0] a,
    input  logic signed [ACC_W-1:0] b,
    output logic                    ovf
  );
    logic [ACC_W:0] w;
    w   = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    ovf = w[ACC_W] ^ w[ACC_W-1];
    if (!ovf) begin
      return w[ACC_W-1:0];
    end else if (w[ACC_W]) begin
      return {1'b1, {(ACC_W-1){1'b0}}};
    end else begin
      return {1'b0, {(ACC_W-1){1'b1}}};
    end
  endfunction
`else
  function automatic logic signed [ACC_W-1:0] acc_add(
    input  logic signed [ACC_W-1:0] a,
    input  logic signed [ACC_W-1:0] b,
    output logic                    ovf
  );
    ovf = 1'b0;
    return a + b;
  endfunction
`endif

  state_t                   state_q, state_d;
  logic        [LEN_W-1:0]  len_q, len_d;
  logic        [LEN_W-1:0]  count_q, count_d;
  logic        [1:0]        op_q, op_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     sat_q, sat_d;

  logic signed [ACC_W-1:0]  in_ext;
  logic signed [ACC_W-1:0]  comb_val;
  logic                     comb_ovf;
  logic                     first_elem;

  assign in_ext     = ACC_W'(bus.in_data);
  assign first_elem = (count_q == '0);

  // Combine the incoming element with the running value for the latched op.
  always_comb begin
    comb_val = acc_q;
    comb_ovf = 1'b0;
    case (op_q)
      OP_MAX:  comb_val = (first_elem || (in_ext > acc_q)) ? in_ext : acc_q;
      OP_MIN:  comb_val = (first_elem || (in_ext < acc_q)) ? in_ext : acc_q;
      default: comb_val = acc_add(acc_q, in_ext, comb_ovf);
    endcase
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    count_d = count_q;
    op_d    = op_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          len_d   = bus.cfg_len;
          op_d    = bus.cfg_op;
          count_d = '0;
          acc_d   = '0;
          sat_d   = 1'b0;
          state_d = (bus.cfg_len == '0) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (bus.in_valid) begin
          acc_d   = comb_val;
          sat_d   = sat_q | comb_ovf;
          count_d = count_q + LEN_W'(1);
          if (count_q == (len_q - LEN_W'(1))) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      count_q <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
    end
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_data  = acc_q;
  assign bus.out_count = count_q;
  assign bus.sat       = sat_q;

endmodule

// File: tb/tb_pe_accum_stage.sv
// Bench for pe_accum_stage: directed vector table, randomized runs against a
// reference model, reset corner cases, and an 8-bit instance for overflow.
module tb_pe_accum_stage;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pe_accum_stage_if #(.DATA_W(32), .ACC_W(48), .LEN_W(16)) b();
  pe_accum_stage_if #(.DATA_W(8),  .ACC_W(8),  .LEN_W(4))  s();

  pe_accum_stage #(.DATA_W(32), .ACC_W(48), .LEN_W(16)) u_main (
    .clk(clk), .rst_n(rst_n), .bus(b)
  );
  pe_accum_stage #(.DATA_W(8), .ACC_W(8), .LEN_W(4)) u_small (
    .clk(clk), .rst_n(rst_n), .bus(s)
  );

  typedef struct {
    int     len;
    int     op;
    int     gap;
    int     hold;
    int     d[4];
    longint exp_d;
  } vec_t;

  vec_t   tbl[7];
  int     n_pass  = 0;
  int     n_total = 0;
  longint vq[$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic set_vec(input int idx, input int len, input int op, input int gap,
                         input int hold, input int d0, input int d1, input int d2,
                         input int d3, input longint exp_d);
    tbl[idx].len  = len;  tbl[idx].op   = op;
    tbl[idx].gap  = gap;  tbl[idx].hold = hold;
    tbl[idx].d[0] = d0;   tbl[idx].d[1] = d1;
    tbl[idx].d[2] = d2;   tbl[idx].d[3] = d3;
    tbl[idx].exp_d = exp_d;
  endtask

  // Reference: sum/max/min over vq with ACC_W-bit clamping or wrapping.
  function automatic longint model(input int op, input int accw, output bit satf);
    longint acc, mx, mn, v;
    mx   = (64'sd1 <<< (accw - 1)) - 1;
    mn   = -mx - 1;
    acc  = 0;
    satf = 1'b0;
    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      if (op == 1)      acc = (i == 0 || v > acc) ? v : acc;
      else if (op == 2) acc = (i == 0 || v < acc) ? v : acc;
      else begin
        acc = acc + v;
`ifdef PE_ACCUM_SATURATE_EN
        if (acc > mx)      begin acc = mx; satf = 1'b1; end
        else if (acc < mn) begin acc = mn; satf = 1'b1; end
`else
        if (acc > mx)      acc = acc - 2 * (mx + 1);
        else if (acc < mn) acc = acc + 2 * (mx + 1);
`endif
      end
    end
    return acc;
  endfunction

  task automatic idle_inputs();
    b.start = 1'b0; b.cfg_len = '0; b.cfg_op = '0;
    b.in_valid = 1'b0; b.in_data = '0; b.out_ready = 1'b0;
    s.start = 1'b0; s.cfg_len = '0; s.cfg_op = '0;
    s.in_valid = 1'b0; s.in_data = '0; s.out_ready = 1'b0;
  endtask

  // One full reduction on the wide instance; a start is offered during HOLD
  // and again on the handshake cycle, both of which must be ignored.
  task automatic run_main(input int len, input int op, input int gap, input int hold,
                          input longint exp_d, input bit exp_sat);
    @(negedge clk);
    b.cfg_len = 16'(len); b.cfg_op = 2'(op); b.start = 1'b1;
    @(negedge clk);
    b.start = 1'b0;
    for (int i = 0; i < len; i++) begin
      for (int g = 0; g < gap; g++) begin
        chk("in_ready_gap", longint'(b.in_ready), 1);
        @(negedge clk);
      end
      b.in_valid = 1'b1; b.in_data = 32'(vq[i]);
      chk("in_ready", longint'(b.in_ready), 1);
      @(negedge clk);
      b.in_valid = 1'b0;
    end
    chk("out_valid_lat1", longint'(b.out_valid), 1);
    chk("out_data", longint'(b.out_data), exp_d);
    chk("out_count", longint'(b.out_count), longint'(len));
    chk("sat", longint'(b.sat), longint'(exp_sat));
    chk("in_ready_hold", longint'(b.in_ready), 0);
    chk("busy_hold", longint'(b.busy), 1);
    for (int h = 0; h < hold; h++) begin
      b.start = 1'b1; b.cfg_len = 16'd7;
      @(negedge clk);
      b.start = 1'b0;
      chk("hold_valid", longint'(b.out_valid), 1);
      chk("hold_data", longint'(b.out_data), exp_d);
      chk("hold_count", longint'(b.out_count), longint'(len));
    end
    b.out_ready = 1'b1; b.start = 1'b1; b.cfg_len = 16'd5;
    @(negedge clk);
    b.out_ready = 1'b0; b.start = 1'b0;
    chk("idle_valid", longint'(b.out_valid), 0);
    chk("idle_busy", longint'(b.busy), 0);
  endtask

  task automatic run_small(input int len, input int op, input longint exp_d,
                           input bit exp_sat);
    @(negedge clk);
    s.cfg_len = 4'(len); s.cfg_op = 2'(op); s.start = 1'b1;
    @(negedge clk);
    s.start = 1'b0;
    for (int i = 0; i < len; i++) begin
      s.in_valid = 1'b1; s.in_data = 8'(vq[i]);
      @(negedge clk);
    end
    s.in_valid = 1'b0;
    chk("s_out_valid", longint'(s.out_valid), 1);
    chk("s_out_data", longint'(s.out_data), exp_d);
    chk("s_out_count", longint'(s.out_count), longint'(len));
    chk("s_sat", longint'(s.sat), longint'(exp_sat));
    s.out_ready = 1'b1;
    @(negedge clk);
    s.out_ready = 1'b0;
    chk("s_idle_busy", longint'(s.busy), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},      longint'(b.busy), 0);
    chk({tag, "_in_ready"},  longint'(b.in_ready), 0);
    chk({tag, "_out_valid"}, longint'(b.out_valid), 0);
    chk({tag, "_out_data"},  longint'(b.out_data), 0);
    chk({tag, "_out_count"}, longint'(b.out_count), 0);
    chk({tag, "_sat"},       longint'(b.sat), 0);
  endtask

  initial begin
    bit     sf;
    longint e;
    int     len, op;
    idle_inputs();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    set_vec(0, 4, 0, 0, 1,  5, -3, 10, 7, 19);
    set_vec(1, 3, 1, 2, 0, -8, -2, -5, 0, -2);
    set_vec(2, 2, 2, 0, 5,  4, -9,  0, 0, -9);
    set_vec(3, 0, 0, 0, 1,  0,  0,  0, 0, 0);
    set_vec(4, 3, 3, 1, 0,  1,  2,  3, 0, 6);
    set_vec(5, 1, 1, 0, 0, -100, 0, 0, 0, -100);
    set_vec(6, 2, 2, 0, 2, 50, 60,  0, 0, 50);
    for (int t = 0; t < 7; t++) begin
      vq.delete();
      for (int i = 0; i < tbl[t].len; i++) vq.push_back(longint'(tbl[t].d[i]));
      run_main(tbl[t].len, tbl[t].op, tbl[t].gap, tbl[t].hold, tbl[t].exp_d, 1'b0);
    end

    for (int r = 0; r < 20; r++) begin
      len = int'($urandom_range(1, 8));
      op  = int'($urandom_range(0, 3));
      vq.delete();
      for (int i = 0; i < len; i++) vq.push_back(longint'(int'($urandom())));
      e = model(op, 48, sf);
      run_main(len, op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), e, sf);
    end

    // Reset in the middle of an accumulation discards the partial result.
    @(negedge clk);
    b.cfg_len = 16'd4; b.cfg_op = 2'd0; b.start = 1'b1;
    @(negedge clk);
    b.start = 1'b0;
    b.in_valid = 1'b1; b.in_data = 32'sd5;
    @(negedge clk);
    b.in_data = -32'sd3;
    @(negedge clk);
    b.in_valid = 1'b0;
    rst_n = 1'b0;
    #1 chk_all_zero("rst_accum");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_valid", longint'(b.out_valid), 0);
    end
    vq.delete(); vq.push_back(3);
    run_main(1, 0, 0, 0, 3, 1'b0);

    // Reset while holding a result: nothing reappears after release.
    vq.delete(); vq.push_back(42);
    @(negedge clk);
    b.cfg_len = 16'd1; b.cfg_op = 2'd0; b.start = 1'b1;
    @(negedge clk);
    b.start = 1'b0; b.in_valid = 1'b1; b.in_data = 32'sd42;
    @(negedge clk);
    b.in_valid = 1'b0;
    chk("pre_rst_hold_valid", longint'(b.out_valid), 1);
    rst_n = 1'b0;
    #1 chk_all_zero("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_hold_valid", longint'(b.out_valid), 0);
    end

    // Narrow instance: overflow behaviour and sticky saturation.
    vq.delete(); vq.push_back(100); vq.push_back(100);
`ifdef PE_ACCUM_SATURATE_EN
    run_small(2, 0, 127, 1'b1);
`else
    run_small(2, 0, -56, 1'b0);
`endif
    vq.delete(); vq.push_back(100); vq.push_back(100); vq.push_back(-100);
`ifdef PE_ACCUM_SATURATE_EN
    run_small(3, 0, 27, 1'b1);
`else
    run_small(3, 0, 100, 1'b0);
`endif
    vq.delete(); vq.push_back(1); vq.push_back(2);
    run_small(2, 0, 3, 1'b0);
    vq.delete(); vq.push_back(-128); vq.push_back(-128); vq.push_back(127);
    run_small(3, 1, 127, 1'b0);
    for (int r = 0; r < 12; r++) begin
      len = int'($urandom_range(1, 6));
      op  = int'($urandom_range(0, 3));
      vq.delete();
      for (int i = 0; i < len; i++) vq.push_back(longint'($urandom_range(0, 255)) - 128);
      e = model(op, 8, sf);
      run_small(len, op, e, sf);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pe_accum_stage.md
PE_ACCUM_STAGE -- requirements
Module: pe_accum_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, signed width of each consumed PE result.
REQ-002 SHALL have parameter ACC_W, default 48, signed accumulator/result width; ACC_W >= DATA_W.
REQ-003 SHALL have parameter LEN_W, default 16, width of the reduction length.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a reduction.
REQ-007 SHALL have port cfg_len  input  LEN_W  element count, sampled on accepted start.
REQ-008 SHALL have port cfg_op  input  2  00 sum, 01 max, 10 min, 11 sum; sampled on accepted start.
REQ-009 SHALL have port in_valid  input  1  PE output word valid.
REQ-010 SHALL have port in_data  input  DATA_W  signed PE output word.
REQ-011 SHALL have port in_ready  output  1  stage accepts in_data.
REQ-012 SHALL have port out_valid  output  1  reduction result valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts result.
REQ-014 SHALL have port out_data  output  ACC_W  signed reduction result.
REQ-015 SHALL have port out_count  output  LEN_W  number of elements consumed.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-017 SHALL have port sat  output  1  sticky saturation flag for the current reduction.

Function
REQ-018 SHALL implement three states: IDLE, ACCUM, HOLD.
REQ-019 IDLE: in_ready=0, out_valid=0; start with cfg_len!=0 -> ACCUM, clear count, sat=0, latch cfg_len/cfg_op.
REQ-020 IDLE: start with cfg_len==0 -> HOLD with out_data=0, out_count=0.
REQ-021 ACCUM: in_ready=1; a transfer occurs when in_valid&&in_ready; no transfer leaves state unchanged.
REQ-022 On each transfer, in_data SHALL be sign-extended to ACC_W and combined: sum adds; max/min keep greater/lesser signed value.
REQ-023 For max/min, the first transfer SHALL load the accumulator directly.
REQ-024 Transfer when count == len-1 -> HOLD next cycle; out_valid asserts the cycle after the final transfer (latency 1).
REQ-025 HOLD: out_valid=1, in_ready=0, out_data/out_count stable until out_ready; out_valid&&out_ready -> IDLE.
REQ-026 start SHALL be ignored while busy=1.
REQ-027 A start in the same cycle as the HOLD->IDLE handshake SHALL be ignored; a new start needs IDLE.
REQ-028 out_count SHALL equal transfers accepted in the current reduction; it does not wrap, as it never exceeds cfg_len.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, in_ready=0, out_valid=0, out_data=0, out_count=0, busy=0, sat=0.
REQ-030 Reset mid-ACCUM or mid-HOLD SHALL discard the partial result; no result is emitted after release.
REQ-031 Reset release SHALL take effect synchronously to clk; first start is accepted on the first edge with rst_n high.

Configuration
REQ-032 Macro PE_ACCUM_SATURATE_EN SHALL select sum overflow behaviour.
REQ-033 With PE_ACCUM_SATURATE_EN defined, a sum overflow SHALL clamp to signed ACC_W max/min and set sat until the next accepted start.
REQ-034 Without PE_ACCUM_SATURATE_EN, sums SHALL wrap modulo 2^ACC_W and sat SHALL be constant 0.
REQ-035 max/min SHALL never set sat in either build.

Verification
REQ-036 start, cfg_len=4, op=00, inputs 5,-3,10,7 back-to-back -> out_valid one cycle after 4th transfer, out_data=19, out_count=4.
REQ-037 start, cfg_len=3, op=01, inputs -8,-2,-5 with in_valid gaps -> out_data=-2, out_count=3; in_ready stays 1 during gaps.
REQ-038 cfg_len=2, op=10, inputs 4,-9, out_ready held low 5 cycles -> out_data=-9 stable, in_ready=0, second start ignored.
REQ-039 cfg_len=0 start -> out_valid next cycle, out_data=0, out_count=0.
REQ-040 rst_n low after 2 of 4 transfers -> all outputs 0 immediately; after release, cfg_len=1, op=00, input 3 -> out_data=3.
REQ-041 ACC_W=DATA_W=8, op=00, inputs 100,100 -> with macro out_data=127, sat=1; without macro out_data=-56, sat=0.
